// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: request/grant and broadcast signals of the common data bus
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 6,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 3
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic                      cdb_stall;
  logic [15:0]               conflict_cnt;
  modport master (output req, req_data, cdb_stall, input gnt, cdb_valid, cdb_tag, cdb_data, conflict_cnt);
  modport slave  (input req, req_data, cdb_stall, output gnt, cdb_valid, cdb_tag, cdb_data, conflict_cnt);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter registering one station result per cycle onto the CDB
module cdb_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 3
) (
  input logic          CLK,
  input logic          RST,
  cdb_arbiter_if.slave bus
);
  localparam logic [TAG_W-1:0] LAST = TAG_W'(NUM_REQ - 1);
  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d, rr_q, rr_d, ptr, j, sel;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                hit, hold, grant;
  logic [DATA_W-1:0]   rd [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rd
    assign rd[i] = bus.req_data[i*DATA_W +: DATA_W];
  end
  // first requester at or after the round-robin pointer, wrapping; stray pointer values restart at 0
  always_comb begin
    ptr = (rr_q > LAST) ? '0 : rr_q;
    j   = ptr;
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && bus.req[j]) begin
        hit = 1'b1;
        sel = j;
      end
      j = (j == LAST) ? '0 : j + 1'b1;
    end
  end
  // a stalled valid broadcast blocks the slot; otherwise a grant loads it or the bus goes idle
  always_comb begin
    hold    = valid_q && bus.cdb_stall;
    grant   = !RST && !hold && hit;
    valid_d = grant || hold;
    tag_d   = grant ? sel : hold ? tag_q : '1;
    data_d  = grant ? rd[sel] : data_q;
    rr_d    = grant ? ((sel == LAST) ? '0 : sel + 1'b1) : rr_q;
    cnt_d   = (grant && $countones(bus.req) >= 2 && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  // broadcast, pointer and conflict counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      tag_q   <= '1;
      data_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.gnt          = grant ? NUM_REQ'(1) << sel : '0;
  assign bus.cdb_valid    = valid_q;
  assign bus.cdb_tag      = tag_q;
  assign bus.cdb_data     = data_q;
  assign bus.conflict_cnt = cnt_q;
endmodule
